sel_encoder_arbiter: RTL and testbench
======================================

Name: sel_encoder_arbiter

Overview:
- Inverse companion to the 1-bit-to-one-hot select decoder.
- Takes two request lines from competing sources and produces a registered 1-bit binary select plus a consistent one-hot grant.
- The binary select feeds the existing select decoder and datapath muxes. The one-hot grant returns to the requesters.
- Two-requester round-robin arbiter with a hold/release handshake. Only one source owns the shared resource at a time.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles a grant is held before forced release (used only with the optional feature).
- CNT_W, 8: width of the hold counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  arbiter enable; low forces release and idle.
- req  input  2  request lines; req[0] = source 0, req[1] = source 1; level-sensitive.
- done  input  1  owner's release strobe, one cycle.
- sel  output  1  registered binary select: 0 = source 0, 1 = source 1; valid only when valid=1.
- valid  output  1  high while a grant is active.
- grant  output  2  registered one-hot grant; always equals (valid ? (sel ? 2'b10 : 2'b01) : 2'b00).
- timeout  output  1  one-cycle pulse on forced release (tied 0 without the optional feature).

Behaviour:
- Reset (sync, active-high; has priority over all other inputs):
  - state = IDLE, sel = 0, valid = 0, grant = 2'b00, timeout = 0.
  - last_owner = 1, so source 0 wins the first tie.
  - Hold counter = 0.
- States: IDLE, OWN0, OWN1, GAP.
- IDLE:
  - enable=0 or req=00: stay IDLE.
  - req=01: go to OWN0. req=10: go to OWN1.
  - req=11: go to OWN(not last_owner).
  - Outputs update on the same edge as the transition: latency is 1 cycle from req sampled to valid/grant/sel asserted.
- OWNx (x = 0 or 1):
  - valid=1, sel=x.
  - Hold while enable=1, req[x]=1 and done=0.
  - Release when done=1, req[x]=0, or enable=0 is sampled. On the next edge: go to GAP, valid=0, grant=00, last_owner=x.
  - sel keeps its last value while invalid.
  - Requests from the other source are ignored while owned; there is no preemption.
- GAP:
  - Exactly one dead cycle with valid=0, then IDLE unconditionally.
  - Guarantees a break-before-make at the decoder, so no two sources are enabled in adjacent cycles.
  - A pending request is re-arbitrated in IDLE.
  - Minimum ownership turnaround is therefore 3 edges: release, GAP, IDLE→OWN.
- Simultaneous events:
  - done=1 on the same cycle as the grant edge: ignored. done is only sampled while in OWNx.
  - done=1 while in IDLE or GAP: ignored.
  - enable falling in IDLE: no effect. enable falling in OWNx: treated as release.
- Round-robin:
  - last_owner updates only on release, not on grant.
  - Under continuous req=11 with a done after every grant, grants alternate 0,1,0,1…
- Reset mid-ownership: grant drops to 00 on the reset edge; no GAP is inserted.
- Invariant, checked by bench assertion: grant is never 2'b11.

Optional Feature:
- Macro: SEL_TIMEOUT_EN.
- Defined:
  - Hold counter clears on entry to OWNx and increments each cycle in OWNx.
  - When the counter equals TIMEOUT_CYCLES-1 and no other release condition holds, release is forced. The next edge goes to GAP, last_owner = x, and timeout pulses 1 for that cycle.
  - A normal release in the same cycle takes precedence and timeout stays 0.
- Undefined:
  - No counter is synthesized; timeout is tied 0.
  - Ownership is unbounded.

Test Plan:
- Reset then req=01 at cycle 2 → cycle 3: valid=1, sel=0, grant=01. done pulse at cycle 6 → cycle 7: grant=00 (GAP). Cycle 8: IDLE.
- req=11 held, done pulsed once per ownership → grant sequence 01, 10, 01, 10 with exactly one valid=0 GAP cycle plus one IDLE cycle between each.
- Owning source 1, drop req[1] while req[0]=1 → next edge GAP; then IDLE, then grant=01 two edges later. last_owner=1 is confirmed by the next tie going to source 0.
- Owning source 0, deassert enable for 1 cycle → release to GAP. With enable=0 held through IDLE, no grant is issued despite req=11.
- Reset asserted during OWN1 → same edge: grant=00, valid=0, sel=0. After reset, req=11 → source 0 granted.
- With SEL_TIMEOUT_EN and TIMEOUT_CYCLES=4: req=01 held, done=0 → valid high for exactly 4 cycles, timeout=1 on the GAP cycle, then re-grant to source 0. Without the macro: grant held indefinitely (200 cycles checked), timeout=0.

Source files
------------

// File: rtl/sel_encoder_arbiter.sv
// rtl/sel_encoder_arbiter.sv - two-source round-robin arbiter with registered binary select and one-hot grant
// Optional forced-release timeout enabled by defining SEL_TIMEOUT_EN.
module sel_encoder_arbiter #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] req,
  input  logic       done,
  output logic       sel,
  output logic       valid,
  output logic [1:0] grant,
  output logic       timeout
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1, GAP} state_t;

  state_t     state_q, state_d;
  logic       sel_q, sel_d;
  logic       valid_q, valid_d;
  logic [1:0] grant_q, grant_d;
  logic       last_q, last_d;
  logic       owner;
  logic       rel;

  if (2 ** CNT_W <= TIMEOUT_CYCLES) begin : g_bad_cnt_w
    $error("CNT_W too narrow for TIMEOUT_CYCLES");
  end

`ifdef SEL_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic             force_rel;
`endif

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    owner   = (state_q == OWN1);
    rel     = done || !req[owner] || !enable;
`ifdef SEL_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    force_rel = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif
    case (state_q)
      IDLE: begin
        if (enable && (req != 2'b00)) begin
          // On a tie the source that did not own last time wins.
          sel_d   = (req == 2'b11) ? ~last_q : req[1];
          state_d = sel_d ? OWN1 : OWN0;
`ifdef SEL_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      OWN0, OWN1: begin
`ifdef SEL_TIMEOUT_EN
        if (rel || force_rel) begin
          state_d   = GAP;
          last_d    = owner;
          timeout_d = !rel;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`else
        if (rel) begin
          state_d = GAP;
          last_d  = owner;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
    valid_d = (state_d == OWN0) || (state_d == OWN1);
    grant_d = valid_d ? (sel_d ? 2'b10 : 2'b01) : 2'b00;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      valid_q <= 1'b0;
      grant_q <= 2'b00;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

`ifdef SEL_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign sel   = sel_q;
  assign valid = valid_q;
  assign grant = grant_q;

endmodule

// File: tb/tb_sel_encoder_arbiter.sv
// tb/tb_sel_encoder_arbiter.sv - vector table, corner sequences and random run against a reference model
module tb_sel_encoder_arbiter;

`ifdef SEL_TIMEOUT_EN
  localparam int TO    = 4;
  localparam bit TO_EN = 1'b1;
`else
  localparam int TO    = 255;
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, enable, done;
  logic [1:0] req;
  logic       sel, valid, timeout;
  logic [1:0] grant;

  int errors = 0;
  int checks = 0;

  sel_encoder_arbiter #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .enable(enable), .req(req), .done(done),
    .sel(sel), .valid(valid), .grant(grant), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       rst;
    bit       en;
    bit [1:0] rq;
    bit       dn;
    bit       ev;
    bit       es;
    bit [1:0] eg;
  } vec_t;

  // Reference model: who owns the resource, whether we sit in the dead cycle.
  int m_owner;   // -1 when nobody owns
  bit m_gap;
  int m_last;
  int m_sel;
  int m_held;
  bit m_to;

  task automatic model_step(input bit r, input bit en, input bit [1:0] rq, input bit dn);
    if (r) begin
      m_owner = -1; m_gap = 0; m_last = 1; m_sel = 0; m_held = 0; m_to = 0;
    end else begin
      m_to = 0;
      if (m_gap) begin
        m_gap = 0;
      end else if (m_owner < 0) begin
        if (en && rq != 0) begin
          if (rq == 2'b11) m_owner = 1 - m_last;
          else             m_owner = (rq == 2'b10) ? 1 : 0;
          m_sel  = m_owner;
          m_held = 1;
        end
      end else begin
        bit gone;
        bit expired;
        gone    = dn || !rq[m_owner] || !en;
        expired = TO_EN && (m_held >= TO);
        if (gone || expired) begin
          m_last  = m_owner;
          m_owner = -1;
          m_gap   = 1;
          m_to    = !gone;
        end else begin
          m_held++;
        end
      end
    end
  endtask

  task automatic drive(input bit r, input bit en, input bit [1:0] rq, input bit dn);
    reset = r; enable = en; req = rq; done = dn;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input bit ev, input bit es, input bit [1:0] eg, input bit et);
    checks++;
    if (valid !== ev || sel !== es || grant !== eg || timeout !== et || grant === 2'b11) begin
      errors++;
      $display("FAIL %s: got valid=%b sel=%b grant=%b timeout=%b, want valid=%b sel=%b grant=%b timeout=%b",
               name, valid, sel, grant, timeout, ev, es, eg, et);
    end
  endtask

  vec_t vecs[$];

  initial begin
    vecs = '{
      '{1,1,2'b00,0, 0,0,2'b00},  // reset
      '{0,1,2'b00,0, 0,0,2'b00},
      '{0,1,2'b01,0, 1,0,2'b01},  // grant src0
      '{0,1,2'b01,0, 1,0,2'b01},
      '{0,1,2'b01,1, 0,0,2'b00},  // done -> gap
      '{0,1,2'b01,0, 0,0,2'b00},  // idle
      '{0,1,2'b01,0, 1,0,2'b01},
      '{0,1,2'b00,0, 0,0,2'b00},  // req drop -> gap
      '{0,1,2'b11,0, 0,0,2'b00},
      '{0,1,2'b11,0, 1,1,2'b10},  // tie -> src1
      '{0,1,2'b11,1, 0,1,2'b00},
      '{0,1,2'b11,0, 0,1,2'b00},
      '{0,1,2'b11,0, 1,0,2'b01},  // tie -> src0
      '{0,1,2'b11,1, 0,0,2'b00},
      '{0,1,2'b11,0, 0,0,2'b00},
      '{0,1,2'b11,0, 1,1,2'b10},
      '{0,1,2'b01,0, 0,1,2'b00},  // src1 drops req
      '{0,1,2'b01,0, 0,1,2'b00},
      '{0,1,2'b11,0, 1,0,2'b01},  // tie after src1 -> src0
      '{0,0,2'b11,0, 0,0,2'b00},  // enable low -> gap
      '{0,0,2'b11,0, 0,0,2'b00},
      '{0,0,2'b11,0, 0,0,2'b00},  // disabled idle holds
      '{0,1,2'b11,0, 1,1,2'b10},
      '{1,1,2'b11,0, 0,0,2'b00},  // reset mid own1
      '{0,1,2'b11,0, 1,0,2'b01},  // no gap after reset
      '{0,1,2'b11,1, 0,0,2'b00},
      '{0,1,2'b11,1, 0,0,2'b00},  // done in gap ignored
      '{0,1,2'b11,1, 1,1,2'b10},  // done on grant edge ignored
      '{0,1,2'b11,0, 1,1,2'b10}
    };

    reset = 1; enable = 0; req = 0; done = 0;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].rq, vecs[i].dn);
      check($sformatf("vec%0d", i), vecs[i].ev, vecs[i].es, vecs[i].eg, 1'b0);
    end

    // Long hold on source 0 with done never asserted.
    drive(1, 1, 2'b00, 0);
    check("hold_reset", 0, 0, 2'b00, 0);
`ifdef SEL_TIMEOUT_EN
    for (int i = 0; i < TO; i++) begin
      drive(0, 1, 2'b01, 0);
      check($sformatf("to_hold%0d", i), 1, 0, 2'b01, 0);
    end
    drive(0, 1, 2'b01, 0);
    check("to_gap", 0, 0, 2'b00, 1);
    drive(0, 1, 2'b01, 0);
    check("to_idle", 0, 0, 2'b00, 0);
    drive(0, 1, 2'b01, 0);
    check("to_regrant", 1, 0, 2'b01, 0);
`else
    for (int i = 0; i < 200; i++) begin
      drive(0, 1, 2'b01, 0);
      check($sformatf("hold%0d", i), 1, 0, 2'b01, 0);
    end
`endif

    // Random traffic against the model.
    model_step(1, 0, 2'b00, 0);
    drive(1, 0, 2'b00, 0);
    for (int i = 0; i < 3000; i++) begin
      bit r, en, dn;
      bit [1:0] rq;
      r  = ($urandom_range(0, 63) == 0);
      en = ($urandom_range(0, 15) != 0);
      rq = 2'($urandom_range(0, 3));
      dn = ($urandom_range(0, 7) == 0);
      model_step(r, en, rq, dn);
      drive(r, en, rq, dn);
      check($sformatf("rand%0d", i), (m_owner >= 0), m_sel[0],
            (m_owner >= 0) ? (m_sel[0] ? 2'b10 : 2'b01) : 2'b00, m_to);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
